// File: rtl/othello_pkg.sv
// othello_pkg: cell encodings, direction indices and deltas, and FSM state constants shared by the scanner
package othello_pkg;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;
  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_E  = 3'd2;
  localparam logic [2:0] DIR_SE = 3'd3;
  localparam logic [2:0] DIR_S  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_W  = 3'd6;
  localparam logic [2:0] DIR_NW = 3'd7;
  localparam logic signed [1:0] DIR_DR [8] = '{-2'sd1, -2'sd1, 2'sd0, 2'sd1, 2'sd1, 2'sd1, 2'sd0, -2'sd1};
  localparam logic signed [1:0] DIR_DC [8] = '{2'sd0, 2'sd1, 2'sd1, 2'sd1, 2'sd0, -2'sd1, -2'sd1, -2'sd1};
  typedef logic [3:0] state_t;
  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_HOME_RD  = 4'd1;
  localparam state_t S_HOME_WT  = 4'd2;
  localparam state_t S_DIR_INIT = 4'd3;
  localparam state_t S_STEP     = 4'd4;
  localparam state_t S_WAIT     = 4'd5;
  localparam state_t S_EVAL     = 4'd6;
  localparam state_t S_DIR_NEXT = 4'd7;
  localparam state_t S_FIN      = 4'd8;
  localparam state_t S_FL_SEL   = 4'd9;
  localparam state_t S_FL_WR    = 4'd10;
  localparam state_t S_FL_HOME  = 4'd11;
endpackage

// File: rtl/othello_dir_stepper.sv
// othello_dir_stepper: combinational one-cell step from (row,col) in direction d with edge detection
// ports: i_row/i_col current square, i_d direction; o_row/o_col next square, o_off next square is off-board,
//        o_addr RAM address of next square (row*BOARD_DIM+col, truncated)
module othello_dir_stepper
  import othello_pkg::*;
#(
  parameter int BOARD_DIM = 8,
  parameter int ADDR_W    = 7,
  parameter int COORD_W   = 4
) (
  input  logic [COORD_W-1:0] i_row,
  input  logic [COORD_W-1:0] i_col,
  input  logic [2:0]         i_d,
  output logic [COORD_W-1:0] o_row,
  output logic [COORD_W-1:0] o_col,
  output logic               o_off,
  output logic [ADDR_W-1:0]  o_addr
);
  localparam logic signed [COORD_W:0] DIM_S = (COORD_W+1)'(BOARD_DIM);
  localparam logic [ADDR_W-1:0] DIM_A = ADDR_W'(BOARD_DIM);
  logic signed [COORD_W:0] w_nr, w_nc;
  assign w_nr = $signed({1'b0, i_row}) + (COORD_W+1)'(DIR_DR[i_d]);
  assign w_nc = $signed({1'b0, i_col}) + (COORD_W+1)'(DIR_DC[i_d]);
  assign o_off = w_nr[COORD_W] || w_nc[COORD_W] || w_nr >= DIM_S || w_nc >= DIM_S;
  assign o_row = w_nr[COORD_W-1:0];
  assign o_col = w_nc[COORD_W-1:0];
  assign o_addr = ADDR_W'(o_row) * DIM_A + ADDR_W'(o_col);
endmodule

// File: rtl/othello_move_scanner.sv
// othello_move_scanner: checks one candidate square in all 8 directions against board RAM
// ports: i_clock/i_reset (sync, active-high); i_start/i_player/i_row/i_col request;
//        o_busy/o_done/o_legal/o_dir_mask/o_flip_count status and results;
//        o_mem_req/o_mem_addr/o_mem_wren/o_mem_wdata/i_mem_rdata board RAM port
// macro OTHELLO_SCAN_FLIP_EN: when defined, a legal move is also written back (flanked cells, then home)
module othello_move_scanner
  import othello_pkg::*;
#(
  parameter int BOARD_DIM = 8,
  parameter int ADDR_W    = 7,
  parameter int COORD_W   = 4,
  parameter int RD_LAT    = 1,
  parameter int CNT_W     = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_player,
  input  logic [COORD_W-1:0] i_row,
  input  logic [COORD_W-1:0] i_col,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_legal,
  output logic [7:0]         o_dir_mask,
  output logic [CNT_W-1:0]   o_flip_count,
  output logic               o_mem_req,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic               o_mem_wren,
  output logic [1:0]         o_mem_wdata,
  input  logic [1:0]         i_mem_rdata
);
  localparam logic [COORD_W-1:0] DIM_C = COORD_W'(BOARD_DIM);
  localparam logic [ADDR_W-1:0] DIM_A = ADDR_W'(BOARD_DIM);
  localparam logic [7:0] WAIT_LAST = 8'(RD_LAT - 1);
  state_t r_state;
  logic r_player;
  logic [COORD_W-1:0] r_row, r_col, r_cr, r_cc, r_run;
  logic [2:0] r_d;
  logic [7:0] r_wait, r_mask;
  logic [CNT_W-1:0] r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [COORD_W-1:0] w_nr, w_nc;
  logic w_off;
  logic [ADDR_W-1:0] w_addr, w_home_in;
  logic [1:0] w_own, w_opp;
  logic [CNT_W:0] w_sum;
  othello_dir_stepper #(.BOARD_DIM(BOARD_DIM), .ADDR_W(ADDR_W), .COORD_W(COORD_W)) u_step (
    .i_row(r_cr), .i_col(r_cc), .i_d(r_d),
    .o_row(w_nr), .o_col(w_nc), .o_off(w_off), .o_addr(w_addr)
  );
  assign w_home_in = ADDR_W'(i_row) * DIM_A + ADDR_W'(i_col);
  assign w_own = r_player ? CELL_WHITE : CELL_BLACK;
  assign w_opp = r_player ? CELL_BLACK : CELL_WHITE;
  assign w_sum = {1'b0, r_count} + (CNT_W+1)'(r_run);
  assign o_busy = r_state != S_IDLE && r_state != S_FIN;
  assign o_done = r_state == S_FIN;
  assign o_legal = |r_mask;
  assign o_dir_mask = r_mask;
  assign o_flip_count = r_count;
  assign o_mem_req = o_busy;
`ifdef OTHELLO_SCAN_FLIP_EN
  logic [ADDR_W-1:0] r_home;
  logic [COORD_W-1:0] r_left;
  logic [COORD_W-1:0] r_runs [8];
  assign o_mem_wren = r_state == S_FL_WR || r_state == S_FL_HOME;
  assign o_mem_wdata = o_mem_wren ? w_own : 2'b00;
  assign o_mem_addr = r_state == S_FL_WR ? w_addr : r_state == S_FL_HOME ? r_home : r_addr;
`else
  assign o_mem_wren = 1'b0;
  assign o_mem_wdata = 2'b00;
  assign o_mem_addr = r_addr;
`endif
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_player <= 1'b0;
      r_row <= '0;
      r_col <= '0;
      r_cr <= '0;
      r_cc <= '0;
      r_run <= '0;
      r_d <= '0;
      r_wait <= '0;
      r_mask <= '0;
      r_count <= '0;
      r_addr <= '0;
`ifdef OTHELLO_SCAN_FLIP_EN
      r_home <= '0;
      r_left <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          if (i_start) begin
            r_player <= i_player;
            r_row <= i_row;
            r_col <= i_col;
            r_mask <= '0;
            r_count <= '0;
            r_wait <= '0;
            r_addr <= w_home_in;
`ifdef OTHELLO_SCAN_FLIP_EN
            r_home <= w_home_in;
`endif
            r_state <= (i_row >= DIM_C || i_col >= DIM_C) ? S_FIN : S_HOME_RD;
          end else r_state <= S_IDLE;
        end
        S_HOME_RD: r_state <= S_HOME_WT;
        S_HOME_WT: begin
          if (r_wait == WAIT_LAST) begin
            r_wait <= '0;
            r_state <= i_mem_rdata != CELL_EMPTY ? S_FIN : S_DIR_INIT;
          end else r_wait <= r_wait + 8'd1;
        end
        S_DIR_INIT: begin
          r_d <= DIR_N;
          r_run <= '0;
          r_cr <= r_row;
          r_cc <= r_col;
          r_state <= S_STEP;
        end
        S_STEP: begin
          if (w_off) r_state <= S_DIR_NEXT;
          else begin
            r_cr <= w_nr;
            r_cc <= w_nc;
            r_addr <= w_addr;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            r_wait <= '0;
            r_state <= S_EVAL;
          end else r_wait <= r_wait + 8'd1;
        end
        S_EVAL: begin
          if (i_mem_rdata == w_opp) begin
            r_run <= r_run + COORD_W'(1);
            r_state <= S_STEP;
          end else begin
            if (i_mem_rdata == w_own && r_run != '0) begin
              r_mask[r_d] <= 1'b1;
              r_count <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
`ifdef OTHELLO_SCAN_FLIP_EN
              r_runs[r_d] <= r_run;
`endif
            end
            r_state <= S_DIR_NEXT;
          end
        end
        S_DIR_NEXT: begin
          if (r_d == DIR_NW) begin
`ifdef OTHELLO_SCAN_FLIP_EN
            r_d <= DIR_N;
            r_state <= |r_mask ? S_FL_SEL : S_FIN;
`else
            r_state <= S_FIN;
`endif
          end else begin
            r_d <= r_d + 3'd1;
            r_run <= '0;
            r_cr <= r_row;
            r_cc <= r_col;
            r_state <= S_STEP;
          end
        end
`ifdef OTHELLO_SCAN_FLIP_EN
        S_FL_SEL: begin
          if (r_mask[r_d]) begin
            r_cr <= r_row;
            r_cc <= r_col;
            r_left <= r_runs[r_d];
            r_state <= S_FL_WR;
          end else if (r_d == DIR_NW) r_state <= S_FL_HOME;
          else r_d <= r_d + 3'd1;
        end
        S_FL_WR: begin
          r_cr <= w_nr;
          r_cc <= w_nc;
          if (r_left == COORD_W'(1)) begin
            if (r_d == DIR_NW) r_state <= S_FL_HOME;
            else begin
              r_d <= r_d + 3'd1;
              r_state <= S_FL_SEL;
            end
          end else r_left <= r_left - COORD_W'(1);
        end
        S_FL_HOME: r_state <= S_FIN;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_othello_move_scanner.sv
// tb_othello_move_scanner: directed and random scans checked against a board-level reference model
module tb_othello_move_scanner;
  localparam int RDL = 2;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, player = 1'b0;
  logic [3:0] row = '0, col = '0;
  logic busy, done, legal, mem_req, mem_wren;
  logic [7:0] mask;
  logic [5:0] cnt;
  logic [6:0] addr;
  logic [1:0] wdata, rdata;
  logic [1:0] mem [128];
  logic [1:0] pipe [RDL];
  int board [8][8];
  int cmp = 0, mism = 0;
  int exp_mask, exp_cnt, exp_lat;
  logic [127:0] exp_reads, obs_reads;
  int exp_wr[$], obs_wr[$];

  always #5 clk = ~clk;

  othello_move_scanner #(.RD_LAT(RDL)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_player(player), .i_row(row), .i_col(col),
    .o_busy(busy), .o_done(done), .o_legal(legal), .o_dir_mask(mask), .o_flip_count(cnt),
    .o_mem_req(mem_req), .o_mem_addr(addr), .o_mem_wren(mem_wren), .o_mem_wdata(wdata),
    .i_mem_rdata(rdata)
  );

  assign rdata = pipe[RDL-1];
  always @(posedge clk) begin
    pipe[0] <= mem[addr];
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    cmp++;
    assert (got === want) else begin
      mism++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic clear_board();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) board[r][c] = 0;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 128; i++) mem[i] = i < 64 ? 2'(board[i/8][i%8]) : 2'b11;
  endtask

  function automatic void model(input int pl, input int r, input int c);
    int dr[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    int dc[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int own = pl ? 2 : 1;
    int opp = pl ? 1 : 2;
    exp_mask = 0;
    exp_cnt = 0;
    exp_reads = '0;
    exp_wr.delete();
    if (r >= 8 || c >= 8) begin
      exp_lat = 1;
      return;
    end
    exp_reads[r*8+c] = 1'b1;
    if (board[r][c] != 0) begin
      exp_lat = 2 + RDL;
      return;
    end
    exp_lat = 3 + RDL;
    for (int d = 0; d < 8; d++) begin
      int rr = r, cc = c, run = 0, nrd = 0, off = 0, pass = 0;
      while (1) begin
        rr += dr[d];
        cc += dc[d];
        if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
          off = 1;
          break;
        end
        nrd++;
        exp_reads[rr*8+cc] = 1'b1;
        if (board[rr][cc] == opp) run++;
        else begin
          pass = (board[rr][cc] == own && run > 0) ? 1 : 0;
          break;
        end
      end
      exp_lat += nrd * (2 + RDL) + off + 1;
      if (pass != 0) begin
        exp_mask |= 1 << d;
        exp_cnt += run;
        for (int k = 1; k <= run; k++) exp_wr.push_back(((r + k*dr[d])*8 + c + k*dc[d])*4 + own);
      end
    end
    if (exp_mask != 0) exp_wr.push_back((r*8+c)*4 + own);
  endfunction

  task automatic run_scan(input int pl, input int r, input int c);
    int n;
    bit poke;
    load_mem();
    model(pl, r, c);
    obs_reads = '0;
    obs_wr.delete();
    poke = exp_lat > 4;
    player = 1'(pl);
    row = 4'(r);
    col = 4'(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    player = 1'($urandom);
    row = 4'($urandom);
    col = 4'($urandom);
    n = 1;
    if (r < 8 && c < 8) chk("busy_after_start", busy, 1);
    while (!done && n < 1000) begin
      if (mem_req && !mem_wren) obs_reads[addr] = 1'b1;
      if (mem_wren) obs_wr.push_back(int'(addr)*4 + int'(wdata));
      start = poke && n == 2;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
`ifndef OTHELLO_SCAN_FLIP_EN
    chk("latency", n, exp_lat);
    chk("no_writes", obs_wr.size(), 0);
`else
    chk("write_count", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) chk("write_item", obs_wr[i], exp_wr[i]);
`endif
    chk("legal", legal, exp_mask != 0);
    chk("dir_mask", mask, exp_mask);
    chk("flip_count", cnt, exp_cnt);
    chk("busy_at_done", busy, 0);
    chk("read_set", obs_reads, exp_reads);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("mask_held", mask, exp_mask);
  endtask

  task automatic board_t1();
    clear_board();
    board[3][3] = 2;
    board[3][4] = 1;
    board[4][3] = 1;
    board[4][4] = 2;
  endtask

  initial begin
    int seen;
    clear_board();
    load_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_legal", legal, 0);
    chk("rst_mask", mask, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_wdata", wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    board_t1();
    run_scan(0, 2, 3);
    chk("t1_mask", mask, 8'h10);
    chk("t1_cnt", cnt, 1);
    chk("t1_legal", legal, 1);
    chk("t1_read27", obs_reads[27], 1);
`ifdef OTHELLO_SCAN_FLIP_EN
    chk("t6_nwr", obs_wr.size(), 2);
    if (obs_wr.size() == 2) begin
      chk("t6_wr0", obs_wr[0], 27*4+1);
      chk("t6_wr1", obs_wr[1], 19*4+1);
    end
`endif

    run_scan(0, 3, 3);
    chk("t2_mask", mask, 0);
    chk("t2_legal", legal, 0);
    chk("t2_cnt", cnt, 0);
    chk("t2_reads", obs_reads, 128'd1 << 27);

    clear_board();
    board[0][6] = 2;
    board[0][7] = 2;
    board[1][0] = 1;
    run_scan(0, 0, 5);
    chk("t3_mask", mask, 0);
    chk("t3_no_read8", obs_reads[8], 0);

    clear_board();
    board[3][3] = 2;
    board[2][3] = 2;
    board[3][2] = 2;
    board[4][4] = 1;
    board[2][4] = 1;
    board[4][2] = 1;
    run_scan(0, 2, 2);
    chk("t4_mask", mask, 8'h1C);
    chk("t4_cnt", cnt, 3);

    board_t1();
    load_mem();
    player = 1'b0;
    row = 4'd2;
    col = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_req", mem_req, 0);
    chk("t5_done", done, 0);
    chk("t5_mask", mask, 0);
    chk("t5_cnt", cnt, 0);
    chk("t5_legal", legal, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("t5_no_done", seen, 0);
    run_scan(0, 2, 3);
    chk("t5_mask_again", mask, 8'h10);
    chk("t5_cnt_again", cnt, 1);

    run_scan(1, 9, 2);
    chk("oob_mask", mask, 0);

    for (int it = 0; it < 60; it++) begin
      int r, c, v;
      for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) begin
        v = $urandom_range(0, 19);
        board[i][j] = v < 7 ? 0 : v < 12 ? 1 : v < 19 ? 2 : 3;
      end
      r = $urandom_range(0, 8);
      c = $urandom_range(0, 8);
      if (r < 8 && c < 8 && $urandom_range(0, 3) != 0) board[r][c] = 0;
      run_scan(int'($urandom_range(0, 1)), r, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
